// File: rtl/einstein_kbd_matrix.sv
// einstein_kbd_matrix
//   Converts MiSTer PS/2 key events into the Einstein 8x8 active-low keyboard
//   matrix plus the SHIFT/CTRL/GRAPH modifier lines read by the machine core.
//
// Ports
//   clk_sys   in   system clock (32 MHz)
//   reset     in   asynchronous, active-high reset
//   ps2_key   in   [10] toggle, [9] press(1)/release(0), [8] E0 flag, [7:0] set-2 code
//   kb_row    in   row select from PSG port A, active-low (bit r low = row r)
//   kb_col    out  column return to PSG port B, active-low (registered)
//   kb_shift  out  0 while either shift key is held (registered)
//   kb_ctrl   out  0 while either ctrl key is held (registered)
//   kb_graph  out  0 while either alt key is held (registered)
//
// Matrix state is one bit per key, index = row*8 + col, 1 = held.
module einstein_kbd_matrix (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  kb_row,
  output logic [7:0]  kb_col,
  output logic        kb_shift,
  output logic        kb_ctrl,
  output logic        kb_graph
);

  typedef enum logic [2:0] {
    MOD_NONE,
    MOD_LSH,
    MOD_RSH,
    MOD_LCTL,
    MOD_RCTL,
    MOD_LALT,
    MOD_RALT
  } mod_id_e;

  // State
  logic [63:0] matrix_q, matrix_d;
  logic        lsh_q, lsh_d, rsh_q, rsh_d;
  logic        lctl_q, lctl_d, rctl_q, rctl_d;
  logic        lalt_q, lalt_d, ralt_q, ralt_d;
  logic        tog_q, tog_d;
  logic        primed_q, primed_d;
  logic [7:0]  kb_col_q, kb_col_d;
  logic        kb_shift_q, kb_shift_d;
  logic        kb_ctrl_q, kb_ctrl_d;
  logic        kb_graph_q, kb_graph_d;

  // Decode results
  logic [8:0]  key9;
  logic [6:0]  lut;       // {hit, row[2:0], col[2:0]}
  mod_id_e     mod_id;
  logic        evt;
  logic        press;
  logic [7:0]  col_sel;

  assign key9  = ps2_key[8:0];
  assign press = ps2_key[9];

  // Scancode lookup. The E0 flag is part of the key, so an extended-only entry
  // never matches its non-extended twin (e.g. keypad 8 vs cursor up).
  always_comb begin
    lut    = 7'd0;
    mod_id = MOD_NONE;
    case (key9)
      // modifiers live outside the matrix
      9'h012: mod_id = MOD_LSH;
      9'h059: mod_id = MOD_RSH;
      9'h014: mod_id = MOD_LCTL;
      9'h114: mod_id = MOD_RCTL;
      9'h011: mod_id = MOD_LALT;
      9'h111: mod_id = MOD_RALT;
      // row 0: digits 1-8
      9'h016: lut = {1'b1, 3'd0, 3'd0};
      9'h01E: lut = {1'b1, 3'd0, 3'd1};
      9'h026: lut = {1'b1, 3'd0, 3'd2};
      9'h025: lut = {1'b1, 3'd0, 3'd3};
      9'h02E: lut = {1'b1, 3'd0, 3'd4};
      9'h036: lut = {1'b1, 3'd0, 3'd5};
      9'h03D: lut = {1'b1, 3'd0, 3'd6};
      9'h03E: lut = {1'b1, 3'd0, 3'd7};
      // row 1: Q A W S E D R F
      9'h015: lut = {1'b1, 3'd1, 3'd0};
      9'h01C: lut = {1'b1, 3'd1, 3'd1};
      9'h01D: lut = {1'b1, 3'd1, 3'd2};
      9'h01B: lut = {1'b1, 3'd1, 3'd3};
      9'h024: lut = {1'b1, 3'd1, 3'd4};
      9'h023: lut = {1'b1, 3'd1, 3'd5};
      9'h02D: lut = {1'b1, 3'd1, 3'd6};
      9'h02B: lut = {1'b1, 3'd1, 3'd7};
      // row 2: T G Y H U J I K
      9'h02C: lut = {1'b1, 3'd2, 3'd0};
      9'h034: lut = {1'b1, 3'd2, 3'd1};
      9'h035: lut = {1'b1, 3'd2, 3'd2};
      9'h033: lut = {1'b1, 3'd2, 3'd3};
      9'h03C: lut = {1'b1, 3'd2, 3'd4};
      9'h03B: lut = {1'b1, 3'd2, 3'd5};
      9'h043: lut = {1'b1, 3'd2, 3'd6};
      9'h042: lut = {1'b1, 3'd2, 3'd7};
      // row 3: O L P ; [ ' ] backslash
      9'h044: lut = {1'b1, 3'd3, 3'd0};
      9'h04B: lut = {1'b1, 3'd3, 3'd1};
      9'h04D: lut = {1'b1, 3'd3, 3'd2};
      9'h04C: lut = {1'b1, 3'd3, 3'd3};
      9'h054: lut = {1'b1, 3'd3, 3'd4};
      9'h052: lut = {1'b1, 3'd3, 3'd5};
      9'h05B: lut = {1'b1, 3'd3, 3'd6};
      9'h05D: lut = {1'b1, 3'd3, 3'd7};
      // row 4: cursor/edit cluster (all E0) plus Esc
      9'h16B: lut = {1'b1, 3'd4, 3'd0};  // left
      9'h174: lut = {1'b1, 3'd4, 3'd1};  // right
      9'h175: lut = {1'b1, 3'd4, 3'd2};  // up
      9'h172: lut = {1'b1, 3'd4, 3'd3};  // down
      9'h16C: lut = {1'b1, 3'd4, 3'd4};  // home
      9'h170: lut = {1'b1, 3'd4, 3'd5};  // insert
      9'h171: lut = {1'b1, 3'd4, 3'd6};  // delete
      9'h076: lut = {1'b1, 3'd4, 3'd7};  // esc
      // row 5: Z X C V B N M ,
      9'h01A: lut = {1'b1, 3'd5, 3'd0};
      9'h022: lut = {1'b1, 3'd5, 3'd1};
      9'h021: lut = {1'b1, 3'd5, 3'd2};
      9'h02A: lut = {1'b1, 3'd5, 3'd3};
      9'h032: lut = {1'b1, 3'd5, 3'd4};
      9'h031: lut = {1'b1, 3'd5, 3'd5};
      9'h03A: lut = {1'b1, 3'd5, 3'd6};
      9'h041: lut = {1'b1, 3'd5, 3'd7};
      // row 6: . / 9 0 - = backspace enter
      9'h049: lut = {1'b1, 3'd6, 3'd0};
      9'h04A: lut = {1'b1, 3'd6, 3'd1};
      9'h046: lut = {1'b1, 3'd6, 3'd2};
      9'h045: lut = {1'b1, 3'd6, 3'd3};
      9'h04E: lut = {1'b1, 3'd6, 3'd4};
      9'h055: lut = {1'b1, 3'd6, 3'd5};
      9'h066: lut = {1'b1, 3'd6, 3'd6};
      9'h05A: lut = {1'b1, 3'd6, 3'd7};
      // row 7: space tab caps ` F1-F4
      9'h029: lut = {1'b1, 3'd7, 3'd0};
      9'h00D: lut = {1'b1, 3'd7, 3'd1};
      9'h058: lut = {1'b1, 3'd7, 3'd2};
      9'h00E: lut = {1'b1, 3'd7, 3'd3};
      9'h005: lut = {1'b1, 3'd7, 3'd4};
      9'h006: lut = {1'b1, 3'd7, 3'd5};
      9'h004: lut = {1'b1, 3'd7, 3'd6};
      9'h00C: lut = {1'b1, 3'd7, 3'd7};
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    // primed_q gates the first post-reset cycle so a stale toggle left on
    // ps2_key is never taken for a fresh keypress.
    evt      = primed_q & (ps2_key[10] ^ tog_q);
    tog_d    = ps2_key[10];
    primed_d = 1'b1;

    matrix_d = matrix_q;
    lsh_d    = lsh_q;
    rsh_d    = rsh_q;
    lctl_d   = lctl_q;
    rctl_d   = rctl_q;
    lalt_d   = lalt_q;
    ralt_d   = ralt_q;

    if (evt) begin
      if (lut[6]) matrix_d[lut[5:0]] = press;
      case (mod_id)
        MOD_LSH:  lsh_d  = press;
        MOD_RSH:  rsh_d  = press;
        MOD_LCTL: lctl_d = press;
        MOD_RCTL: rctl_d = press;
        MOD_LALT: lalt_d = press;
        MOD_RALT: ralt_d = press;
        default:  ;
      endcase
    end

    // Selected rows OR together (wired-AND on the active-low bus); no row
    // selected leaves every column high.
    col_sel = 8'h00;
    for (int r = 0; r < 8; r++) begin
      if (!kb_row[r]) col_sel = col_sel | matrix_q[r*8 +: 8];
    end
    kb_col_d   = ~col_sel;
    kb_shift_d = ~(lsh_q | rsh_q);
    kb_ctrl_d  = ~(lctl_q | rctl_q);
    kb_graph_d = ~(lalt_q | ralt_q);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      matrix_q   <= 64'd0;
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      lctl_q     <= 1'b0;
      rctl_q     <= 1'b0;
      lalt_q     <= 1'b0;
      ralt_q     <= 1'b0;
      tog_q      <= 1'b0;
      primed_q   <= 1'b0;
      kb_col_q   <= 8'hFF;
      kb_shift_q <= 1'b1;
      kb_ctrl_q  <= 1'b1;
      kb_graph_q <= 1'b1;
    end else begin
      matrix_q   <= matrix_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      lctl_q     <= lctl_d;
      rctl_q     <= rctl_d;
      lalt_q     <= lalt_d;
      ralt_q     <= ralt_d;
      tog_q      <= tog_d;
      primed_q   <= primed_d;
      kb_col_q   <= kb_col_d;
      kb_shift_q <= kb_shift_d;
      kb_ctrl_q  <= kb_ctrl_d;
      kb_graph_q <= kb_graph_d;
    end
  end

  assign kb_col   = kb_col_q;
  assign kb_shift = kb_shift_q;
  assign kb_ctrl  = kb_ctrl_q;
  assign kb_graph = kb_graph_q;

endmodule

// File: doc/einstein_kbd_matrix.md
# einstein_kbd_matrix

Translates MiSTer PS/2 key events into the Einstein's 8x8 active-low keyboard matrix plus the SHIFT/CTRL/GRAPH modifier lines. It sits directly upstream of the machine core. The core drives the row select from PSG port A (`kb_row`), and this block returns `kb_col` on PSG port B. The block also drives `kb_shift`, `kb_ctrl` and `kb_graph`, which the core reads through the keyboard mask port.

## Interface
No parameters.
- `clk_sys`  in  1  system clock (32 MHz)
- `reset`  in  1  asynchronous, active-high; clock `clk_sys`
- `ps2_key`  in  11  MiSTer key event: [10] toggle (changes on every event), [9] 1 = pressed / 0 = released, [8] extended (E0) flag, [7:0] set-2 scancode
- `kb_row`  in  8  row select, active-low; bit r low selects matrix row r
- `kb_col`  out  8  column return, active-low; bit c low = a key at (selected row, c) is held
- `kb_shift`  out  1  0 while either shift key is held
- `kb_ctrl`  out  1  0 while either ctrl key is held
- `kb_graph`  out  1  0 while either alt key is held (GRAPH)

## Operation
- **State held:**
  - `matrix[63:0]`, 1 bit per key, 1 = held, index = row*8+col.
  - Separate held bits `lsh`, `rsh`, `lctl`, `rctl`, `lalt`, `ralt`.
  - `tog_q`, the last seen toggle.
  - `primed` flag.
- **Event detect:** an event occurs on a cycle where `primed`=1 and `ps2_key[10]` != `tog_q`. `tog_q` reloads from `ps2_key[10]` every cycle.
- **Priming:** on the first clock after reset deasserts, `primed` sets and `tog_q` loads. No event is generated on that cycle, so a stale toggle is never interpreted as a keypress.
- **Decode:** a combinational lookup of {extended, code} returns {valid, row[2:0], col[2:0]} or a modifier ID.
  - On an event with a matrix hit: `matrix[row*8+col]` <= `ps2_key[9]`.
  - On a modifier hit: the modifier's bit <= `ps2_key[9]`.
  - Unmapped codes are ignored, with no state change.
- **Modifier codes:**
  - Shift: 0x12 = `lsh`, 0x59 = `rsh`.
  - Ctrl: 0x14 non-extended = `lctl`, 0x14 extended = `rctl`.
  - Alt: 0x11 non-extended = `lalt`, 0x11 extended = `ralt`.
  - Modifiers never enter `matrix`.
- **Fixed matrix assignments:**
  - Space 0x29 → (7,0)
  - A 0x1C → (1,1)
  - Enter 0x5A → (6,7)
  - Cursor up E0 0x75 → (4,2)
  - Cursor down E0 0x72 → (4,3)
  - Remaining keys follow the Einstein matrix sheet in docs/keyboard.
- **Extended flag is significant:** a non-extended code that matches only an extended entry is unmapped.
- **Column return:** `kb_col[c]` = NOT( OR over r with `kb_row[r]`=0 of `matrix[r*8+c]` ).
  - If several rows are selected, they combine wired-AND (active-low).
  - If no row is selected, `kb_col` = 0xFF.
- **Modifier outputs:**
  - `kb_shift` = ~(`lsh`|`rsh`)
  - `kb_ctrl` = ~(`lctl`|`rctl`)
  - `kb_graph` = ~(`lalt`|`ralt`)
- **Repeated or mismatched events:** a repeated press of a held key keeps it held. A release of a key not held is harmless. No counting is done.
- **Ghosting:** not modelled; no ghost keys are emulated.

## Timing
- **Reset values:**
  - `kb_col` = 0xFF; `kb_shift` = `kb_ctrl` = `kb_graph` = 1.
  - `matrix` and all modifier bits = 0; `tog_q` = 0; `primed` = 0.
- **Reset mid-operation:** all held keys are released immediately (asynchronously). Priming repeats after release.
- **Event latency:** an event sampled at edge N updates `matrix` or the modifier bit at edge N. The new value is visible on `kb_col` / modifier outputs after edge N+1, because outputs are registered.
- **Row-select latency:** a `kb_row` change visible at edge N appears on `kb_col` after edge N+1 (1 cycle). This is far below the CPU's PSG read-after-write interval.
- **Back-to-back events:** events on consecutive cycles (toggle flipping every clock) are each processed; none are dropped.
- **Simultaneous event and row change:** both take effect in the same cycle. The registered `kb_col` uses the updated matrix one cycle later.
- **Clock domain:** all inputs are synchronous to `clk_sys`; no synchronisers are needed.

## Test plan
- **Reset:** hold reset, then release with `ps2_key`[10]=1. Required: no event; `kb_col`=0xFF; `kb_shift`/`kb_ctrl`/`kb_graph`=1.
- **A press/release:** event {press, non-ext, 0x1C} with `kb_row`=0xFD → `kb_col`=0xFD two cycles after the toggle edge. Switch `kb_row`=0xFE → `kb_col`=0xFF. Release event → 0xFF with `kb_row`=0xFD.
- **Multi-row select:** hold Space (7,0) and Enter (6,7); set `kb_row`=0x3F → `kb_col`=0x7E; set `kb_row`=0x7F → `kb_col`=0xFE.
- **Extended discrimination:** press E0 0x75 → (4,2) held. Press non-ext 0x75 → no matrix change (`kb_row`=0xEF gives `kb_col`=0xFB).
- **Modifiers:** press 0x12 and 0x59, release 0x12 → `kb_shift` stays 0. Release 0x59 → 1. Press E0 0x11 → `kb_graph`=0 and `matrix` unchanged.
- **Stress and reset:** toggle every clock for 16 alternating press/release of A ending in press → A held. Assert reset mid-burst → `kb_col`=0xFF immediately, and the first post-reset cycle generates no event.
